// File: rtl/cpu_pkg.sv
// Shared types and constants for the ALU sequencer.
// Instruction fields, FSM states and the B-operand shifter.
package cpu_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        S_WAIT,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam int OPC_LSB = 13;
    localparam int OP_LSB  = 11;
    localparam int RN_LSB  = 8;
    localparam int RD_LSB  = 5;
    localparam int SH_LSB  = 3;
    localparam int RM_LSB  = 0;

    function automatic word_t shift_b(input word_t v, input logic [1:0] sh);
        word_t r;
        unique case (sh)
            SH_LSL:  r = {v[14:0], 1'b0};
            SH_LSR:  r = {1'b0, v[15:1]};
            SH_ASR:  r = {v[15], v[15:1]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// 8x16 register file: one synchronous write port,
// one operand read port and one debug read port.
module regfile
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we_i,
    input  logic [2:0] waddr_i,
    input  word_t      wdata_i,
    input  logic [2:0] raddr_i,
    output word_t      rdata_o,
    input  logic [2:0] daddr_i,
    output word_t      ddata_o
);

    word_t mem_q [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
    assign ddata_o = mem_q[daddr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving an external combinational ALU:
// decode, operand fetch, execute capture, writeback.
module alu_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] instr,
    output logic        in_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic        alu_z,
    output logic [2:0]  status,
    output logic        done,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    state_t      state_q;
    word_t       ir_q;
    word_t       a_q;
    word_t       b_q;
    word_t       c_q;
    logic [2:0]  status_q;
    logic        done_q;
    logic        err_q;

    logic [2:0]  opc_q;
    logic [1:0]  op_q;
    logic [2:0]  rn_q;
    logic [2:0]  rd_q;
    logic [2:0]  rm_q;
    logic [1:0]  sh_q;
    logic        is_alu_q;
    logic        is_movi_q;
    logic        is_movr_q;
    logic        is_cmp_q;

    logic [2:0]  in_opc;
    logic [1:0]  in_op;
    logic        in_movi;
    logic        in_movr;
    logic        in_alu;

    logic [2:0]  raddr;
    word_t       rdata;
    logic        rf_we;
    logic [2:0]  waddr;
    logic        ovf;

    assign opc_q = ir_q[OPC_LSB +: 3];
    assign op_q  = ir_q[OP_LSB +: 2];
    assign rn_q  = ir_q[RN_LSB +: 3];
    assign rd_q  = ir_q[RD_LSB +: 3];
    assign sh_q  = ir_q[SH_LSB +: 2];
    assign rm_q  = ir_q[RM_LSB +: 3];

    assign is_alu_q  = (opc_q == OPC_ALU);
    assign is_movi_q = (opc_q == OPC_MOV) && (op_q == OP_MOVI);
    assign is_movr_q = (opc_q == OPC_MOV) && (op_q == OP_MOVR);
    assign is_cmp_q  = is_alu_q && (op_q == OP_CMP);

    assign in_opc  = instr[OPC_LSB +: 3];
    assign in_op   = instr[OP_LSB +: 2];
    assign in_movi = (in_opc == OPC_MOV) && (in_op == OP_MOVI);
    assign in_movr = (in_opc == OPC_MOV) && (in_op == OP_MOVR);
    assign in_alu  = (in_opc == OPC_ALU);

    // one read port serves both operand fetches
    assign raddr = (state_q == S_GET_B) ? rm_q : rn_q;
    assign rf_we = (state_q == S_WRITE) && !is_cmp_q;
    assign waddr = is_movi_q ? rn_q : rd_q;

    // signed overflow of A - B, as seen by CMP
    assign ovf = (a_q[15] ^ b_q[15]) & (alu_out[15] ^ a_q[15]);

    regfile u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (rf_we),
        .waddr_i (waddr),
        .wdata_i (c_q),
        .raddr_i (raddr),
        .rdata_o (rdata),
        .daddr_i (dbg_addr),
        .ddata_o (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_WAIT;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_WAIT: begin
                    if (in_valid) begin
                        ir_q <= instr;
                        unique case (1'b1)
                            in_movi: begin
                                c_q     <= {{8{instr[7]}}, instr[7:0]};
                                done_q  <= 1'b1;
                                state_q <= S_WRITE;
                            end
                            in_movr, in_alu: begin
                                state_q <= S_GET_A;
                            end
                            default: begin
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                S_GET_A: begin
                    a_q     <= is_movr_q ? '0 : rdata;
                    state_q <= S_GET_B;
                end
                S_GET_B: begin
                    b_q     <= shift_b(rdata, sh_q);
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    c_q <= alu_out;
                    if (is_cmp_q) begin
                        status_q <= {alu_out[15], ovf, alu_z};
                    end
                    done_q  <= 1'b1;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    state_q <= S_WAIT;
                end
                default: begin
                    state_q <= S_WAIT;
                end
            endcase
        end
    end

    assign in_ready = (state_q == S_WAIT);
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = is_alu_q ? op_q : OP_ADD;
    assign status   = status_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
